// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates a single unified memory port between the MIPS core and a
//   loader/debug host. The core has priority. If the host has waited MAX_WAIT
//   cycles, the host wins one access. The host can also lock the port for a
//   burst.
//
//   Ports
//     clk, rst               single clock, synchronous active-high reset
//     core_req/we/addr/wdata core request channel
//     core_gnt, core_rdata   core grant (access completes) and read data
//     host_req/we/lock       host request, write qualifier, burst lock
//     host_addr/wdata        host address and write data
//     host_gnt, host_rdata   host grant and read data
//     mem_we/addr/wd, mem_rd unified memory (combinational read, clocked write)
//     locked                 high while the host holds the burst lock
//     conflict_cnt           saturating count of cycles with both requesting
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   SHARED       | core priority, host served when idle core or starved
//   HOST_LOCKED  | host owns the port until host_lock drops
module mem_port_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [BUS_WIDTH-1:0] core_addr,
  input  logic [BUS_WIDTH-1:0] core_wdata,
  output logic                 core_gnt,
  output logic [BUS_WIDTH-1:0] core_rdata,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic                 host_lock,
  input  logic [BUS_WIDTH-1:0] host_addr,
  input  logic [BUS_WIDTH-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [BUS_WIDTH-1:0] host_rdata,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wd,
  input  logic [BUS_WIDTH-1:0] mem_rd,
  output logic                 locked,
  output logic [15:0]          conflict_cnt
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic {
    SHARED      = 1'b0,
    HOST_LOCKED = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic [15:0] conflict_nxt;
  logic        starved;

  assign starved = host_req && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SHARED;
      wait_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_nxt;
      conflict_cnt <= conflict_nxt;
    end
  end

  // The grants are combinational so that an access completes in the same
  // cycle it is requested. Reset masks every grant.
  always_comb begin
    core_gnt  = 1'b0;
    host_gnt  = 1'b0;
    state_nxt = state;
    if (!rst) begin
      case (state)
        SHARED: begin
          if (core_req && !starved) begin
            core_gnt = 1'b1;
          end else if (host_req) begin
            host_gnt = 1'b1;
          end
          if (host_gnt && host_lock) begin
            state_nxt = HOST_LOCKED;
          end
        end
        HOST_LOCKED: begin
          host_gnt = host_req;
          if (!host_lock) begin
            state_nxt = SHARED;
          end
        end
        default: state_nxt = SHARED;
      endcase
    end
  end

  // The wait counter measures how long the host has been requesting without
  // service. It holds at the limit until the host is granted or withdraws.
  always_comb begin
    wait_nxt = '0;
    if (host_req && !host_gnt) begin
      wait_nxt = (wait_cnt >= WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + 4'd1;
    end
  end

  always_comb begin
    conflict_nxt = conflict_cnt;
    if (core_req && host_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_nxt = conflict_cnt + 16'd1;
    end
  end

  // When there is no grant, the address and write-data lines show the core
  // inputs. mem_we stays low in that case because it is qualified by a grant.
  always_comb begin
    mem_addr = core_addr;
    mem_wd   = core_wdata;
    if (host_gnt) begin
      mem_addr = host_addr;
      mem_wd   = host_wdata;
    end
  end

  assign mem_we     = (core_gnt && core_we) || (host_gnt && host_we);
  assign core_rdata = core_gnt ? mem_rd : '0;
  assign host_rdata = host_gnt ? mem_rd : '0;
  assign locked     = (state == HOST_LOCKED) && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, host_req, host_we, host_lock;
  logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
  logic        core_gnt, host_gnt, mem_we, locked;
  logic [31:0] core_rdata, host_rdata, mem_addr, mem_wd, mem_rd;
  logic [15:0] conflict_cnt;
  logic [31:0] mem [0:255];

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.BUS_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .locked(locked),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read and clocked write.
  assign mem_rd = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock. The inputs are then driven just after the falling
  // edge, and the outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = 32'h1234_5678;

    // Reset masks grants even with everything requesting.
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b1; host_req = 1'b1; host_we = 1'b1; host_lock = 1'b0;
    core_addr = 32'h10; core_wdata = 32'h0; host_addr = 32'h20; host_wdata = 32'h0;
    #1;
    check("rst_core_gnt", {31'b0, core_gnt}, 32'd0);
    check("rst_host_gnt", {31'b0, host_gnt}, 32'd0);
    check("rst_mem_we",   {31'b0, mem_we},   32'd0);
    check("rst_locked",   {31'b0, locked},   32'd0);
    cyc();
    rst = 1'b0;

    // Core write.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEAD_BEEF;
    host_req = 1'b0; host_we = 1'b0;
    #1;
    check("rst_conflict", {16'b0, conflict_cnt}, 32'd0);
    check("cw_core_gnt",  {31'b0, core_gnt}, 32'd1);
    check("cw_mem_we",    {31'b0, mem_we},   32'd1);
    check("cw_host_gnt",  {31'b0, host_gnt}, 32'd0);
    cyc();

    // Core read-back.
    core_we = 1'b0;
    #1;
    check("cr_rdata",  core_rdata, 32'hDEAD_BEEF);
    check("cr_mem_we", {31'b0, mem_we}, 32'd0);
    cyc();

    // Host read. core_we is asserted without a request and must be ignored.
    core_req = 1'b0; core_we = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
    #1;
    check("hr_host_gnt",   {31'b0, host_gnt}, 32'd1);
    check("hr_core_gnt",   {31'b0, core_gnt}, 32'd0);
    check("hr_host_rdata", host_rdata, 32'h1234_5678);
    check("hr_core_rdata", core_rdata, 32'd0);
    check("hr_mem_we",     {31'b0, mem_we}, 32'd0);
    check("hr_conflict",   {16'b0, conflict_cnt}, 32'd0);
    cyc();

    // Starvation. Both sides request continuously. The host wins cycle 4.
    core_req = 1'b1; core_we = 1'b0; host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("st_core_gnt_%0d", i), {31'b0, core_gnt}, (i == 4) ? 32'd0 : 32'd1);
      check($sformatf("st_host_gnt_%0d", i), {31'b0, host_gnt}, (i == 4) ? 32'd1 : 32'd0);
      cyc();
    end

    // Idle cycle. With no grant, the address lines follow the core inputs.
    core_req = 1'b0; host_req = 1'b0; core_addr = 32'h44; host_addr = 32'h88;
    #1;
    check("st_conflict", {16'b0, conflict_cnt}, 32'd6);
    check("idle_gnts",   {30'b0, core_gnt, host_gnt}, 32'd0);
    check("idle_addr",   mem_addr, 32'h44);
    cyc();

    // Lock entry.
    host_req = 1'b1; host_lock = 1'b1; host_addr = 32'h30;
    #1;
    check("lk_entry_gnt",    {31'b0, host_gnt}, 32'd1);
    check("lk_entry_locked", {31'b0, locked},   32'd0);
    cyc();

    // Hold the lock for 3 cycles while the core requests. The second cycle
    // performs a host write.
    core_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_we = (i == 1); host_wdata = 32'hCAFE_0000 + i;
      #1;
      check($sformatf("lk_locked_%0d", i),   {31'b0, locked},   32'd1);
      check($sformatf("lk_core_gnt_%0d", i), {31'b0, core_gnt}, 32'd0);
      check($sformatf("lk_host_gnt_%0d", i), {31'b0, host_gnt}, 32'd1);
      check($sformatf("lk_mem_we_%0d", i),   {31'b0, mem_we},   (i == 1) ? 32'd1 : 32'd0);
      cyc();
    end
    check("lk_write", mem[8'h30], 32'hCAFE_0001);

    // Drop the lock. The lock is still held during this cycle.
    host_we = 1'b0; host_lock = 1'b0;
    #1;
    check("lk_drop_locked", {31'b0, locked},   32'd1);
    check("lk_drop_core",   {31'b0, core_gnt}, 32'd0);
    cyc();
    #1;
    check("lk_after_locked", {31'b0, locked},   32'd0);
    check("lk_after_core",   {31'b0, core_gnt}, 32'd1);
    check("lk_after_host",   {31'b0, host_gnt}, 32'd0);
    check("lk_conflict",     {16'b0, conflict_cnt}, 32'd10);
    cyc();

    // Re-enter the lock, then reset during the burst.
    core_req = 1'b0; host_req = 1'b1; host_lock = 1'b1;
    cyc();
    core_req = 1'b1; host_we = 1'b1;
    #1;
    check("rl_locked", {31'b0, locked}, 32'd1);
    cyc();
    rst = 1'b1;
    #1;
    check("rl_rst_gnts",   {30'b0, core_gnt, host_gnt}, 32'd0);
    check("rl_rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rl_rst_locked", {31'b0, locked}, 32'd0);
    cyc();
    rst = 1'b0; host_lock = 1'b0; host_we = 1'b0;

    // After reset, the core wins cycles 0-3 of the conflict and the host
    // wins cycle 4.
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 0) begin
        check("rl_locked_after", {31'b0, locked}, 32'd0);
        check("rl_conflict_clr", {16'b0, conflict_cnt}, 32'd0);
      end
      check($sformatf("rl_core_gnt_%0d", i), {31'b0, core_gnt}, (i == 4) ? 32'd0 : 32'd1);
      check($sformatf("rl_host_gnt_%0d", i), {31'b0, host_gnt}, (i == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    #1;
    check("rl_conflict", {16'b0, conflict_cnt}, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, which sets the address, write-data and read-data width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, the host starvation limit in cycles (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports core_req, core_we, input, 1 bit each: MIPS core access request and write qualifier.
REQ-006 SHALL have ports core_addr, core_wdata, input, BUS_WIDTH each: core address and write data.
REQ-007 SHALL have port core_gnt, output, 1 bit: the core access completes this cycle; core holds PCEn/IRWrite while low.
REQ-008 SHALL have port core_rdata, output, BUS_WIDTH: read data for the core.
REQ-009 SHALL have ports host_req, host_we, host_lock, input, 1 bit each: loader/debug request, write qualifier and burst-lock request.
REQ-010 SHALL have ports host_addr, host_wdata, input, BUS_WIDTH each: host address and write data.
REQ-011 SHALL have ports host_gnt, output, 1 bit, and host_rdata, output, BUS_WIDTH: host grant and read data.
REQ-012 SHALL have ports mem_we, output, 1 bit; mem_addr, mem_wd, output, BUS_WIDTH each: drive the unified memory (combinational read, clocked write).
REQ-013 SHALL have port mem_rd, input, BUS_WIDTH: memory read data.
REQ-014 SHALL have port locked, output, 1 bit: high while in HOST_LOCKED.
REQ-015 SHALL have port conflict_cnt, output, 16 bits: saturating count of both-request cycles.

Function
REQ-016 SHALL implement a 2-state FSM: SHARED (reset state) and HOST_LOCKED.
REQ-017 SHALL, in SHARED, grant the core when core_req=1, unless host_req=1 and wait_cnt==MAX_WAIT; in that case it SHALL grant the host.
REQ-018 SHALL, in SHARED, grant the host when host_req=1 and core_req=0.
REQ-019 SHALL assert at most one grant per cycle; grants are combinational from current state, requests and wait_cnt (zero-cycle latency).
REQ-020 SHALL drive mem_addr/mem_wd from the granted requester; with no grant, from core inputs; mem_we = (granted requester's we) AND grant.
REQ-021 SHALL drive core_rdata = mem_rd when core_gnt=1, else 0; the same rule SHALL apply to host_rdata with host_gnt.
REQ-022 SHALL hold wait_cnt (4 bits): +1 each cycle with host_req=1 and host_gnt=0, saturating at MAX_WAIT; cleared on host_gnt=1 or host_req=0.
REQ-023 SHALL move SHARED->HOST_LOCKED at the clock edge ending a cycle where host_gnt=1 and host_lock=1.
REQ-024 SHALL, in HOST_LOCKED, set host_gnt = host_req and core_gnt = 0 regardless of core_req or wait_cnt.
REQ-025 SHALL move HOST_LOCKED->SHARED at the edge where host_lock=0 is sampled; core becomes eligible the next cycle.
REQ-026 SHALL increment conflict_cnt on each cycle with core_req=1 and host_req=1 in either state, saturating at 16'hFFFF.
REQ-027 SHALL ignore core_we/host_we when the respective req=0; no memory write without a grant.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, load state=SHARED, wait_cnt=0 and conflict_cnt=0.
REQ-029 SHALL force core_gnt=0, host_gnt=0, mem_we=0, locked=0 combinationally while rst=1.
REQ-030 SHALL release an active lock on reset mid-burst; after reset deasserts, arbitration starts in SHARED with core priority.

Verification
REQ-031 Core only: core_req=1, we=1, addr=0x10, wdata=0xDEADBEEF -> core_gnt=1, mem_we=1 same cycle; a later read of 0x10 returns 0xDEADBEEF on core_rdata.
REQ-032 Host only: host_req=1, we=0, addr=0x20, core_req=0 -> host_gnt=1, host_rdata=mem_rd, core_rdata=0.
REQ-033 Starvation (MAX_WAIT=4): both request continuously -> core granted cycles 0-3, host granted cycle 4, core cycle 5; conflict_cnt=6 after 6 cycles.
REQ-034 Lock: host granted with host_lock=1, then host_lock held 3 cycles with core_req=1 -> locked=1, core_gnt=0 throughout; core_gnt=1 on the cycle after host_lock=0 is sampled.
REQ-035 Reset mid-lock: rst=1 for 1 cycle during HOST_LOCKED -> gnts and mem_we=0 during rst; locked=0, wait_cnt=0, conflict_cnt=0 after; core wins the next conflict.
